// File: rtl/idex_latch.sv
// idex_latch: ID/EX pipeline register with hold, bubble insertion, sticky halt and saturating perf counters.
module idex_latch #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             en,
  input  logic             stall,
  input  logic             flush,
  input  logic [31:0]      npc_i,
  input  logic [31:0]      Jaddr_i,
  input  logic [31:0]      rdata1_i,
  input  logic [31:0]      rdata2_i,
  input  logic [31:0]      extout_i,
  input  logic             Branch_i,
  input  logic             DRen_i,
  input  logic             DWen_i,
  input  logic             RegWrite_i,
  input  logic             RegDst_i,
  input  logic             halt_i,
  input  logic [1:0]       MemtoReg_i,
  input  logic [1:0]       ALUSrc_i,
  input  logic [3:0]       ALUop_i,
  input  logic [4:0]       Rd_i,
  input  logic [4:0]       Rt_i,
  output logic [31:0]      npc_o,
  output logic [31:0]      Jaddr_o,
  output logic [31:0]      rdata1_o,
  output logic [31:0]      rdata2_o,
  output logic [31:0]      extout_o,
  output logic             Branch_o,
  output logic             DRen_o,
  output logic             DWen_o,
  output logic             RegWrite_o,
  output logic             RegDst_o,
  output logic             halt_o,
  output logic [1:0]       MemtoReg_o,
  output logic [1:0]       ALUSrc_o,
  output logic [3:0]       ALUop_o,
  output logic [4:0]       Rd_o,
  output logic [4:0]       Rt_o,
  output logic             valid_o,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] stall_cnt
);
  // halt_o is excluded from the bubble clear so a bubble can never drop a pending halt.
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      {npc_o, Jaddr_o, rdata1_o, rdata2_o, extout_o, Branch_o, DRen_o, DWen_o, RegWrite_o,
       RegDst_o, MemtoReg_o, ALUSrc_o, ALUop_o, Rd_o, Rt_o} <= '0;
      halt_o     <= 1'b0;
      valid_o    <= 1'b0;
      bubble_cnt <= '0;
      stall_cnt  <= '0;
    end else if (!en) begin
      stall_cnt <= stall_cnt + CNT_W'(~&stall_cnt);
    end else if (flush || stall) begin
      {npc_o, Jaddr_o, rdata1_o, rdata2_o, extout_o, Branch_o, DRen_o, DWen_o, RegWrite_o,
       RegDst_o, MemtoReg_o, ALUSrc_o, ALUop_o, Rd_o, Rt_o} <= '0;
      valid_o    <= 1'b0;
      bubble_cnt <= bubble_cnt + CNT_W'(~&bubble_cnt);
    end else begin
      {npc_o, Jaddr_o, rdata1_o, rdata2_o, extout_o, Branch_o, DRen_o, DWen_o, RegWrite_o,
       RegDst_o, MemtoReg_o, ALUSrc_o, ALUop_o, Rd_o, Rt_o} <=
      {npc_i, Jaddr_i, rdata1_i, rdata2_i, extout_i, Branch_i, DRen_i, DWen_i, RegWrite_i,
       RegDst_i, MemtoReg_i, ALUSrc_i, ALUop_i, Rd_i, Rt_i};
      halt_o  <= halt_o | halt_i;
      valid_o <= 1'b1;
    end
endmodule

// File: tb/tb_idex_latch.sv
// tb_idex_latch: directed table, hand sequences and random stimulus checked against a behavioural model.
module tb_idex_latch;
  typedef struct packed {
    logic [31:0] npc, jaddr, rdata1, rdata2, extout;
    logic        branch, dren, dwen, regwrite, regdst, halt;
    logic [1:0]  memtoreg, alusrc;
    logic [3:0]  aluop;
    logic [4:0]  rd, rt;
  } fields_t;

  typedef struct {
    logic        en, stall, flush, halt;
    logic [31:0] npc;
    logic [31:0] e_npc;
    logic        e_halt, e_valid;
    int          e_bub, e_stl;
  } vec_t;

  logic CLK = 0, nRST = 0, en = 0, stall = 0, flush = 0;
  fields_t din = '0, d0, d1;
  logic v0, v1;
  logic [15:0] bub0, stl0;
  logic [3:0]  bub1, stl1;

  fields_t m;
  logic mv;
  int mb, ms;
  int errors = 0, checks = 0;

  always #5 CLK = ~CLK;

  idex_latch #(.CNT_W(16)) u0 (
    .CLK(CLK), .nRST(nRST), .en(en), .stall(stall), .flush(flush),
    .npc_i(din.npc), .Jaddr_i(din.jaddr), .rdata1_i(din.rdata1), .rdata2_i(din.rdata2),
    .extout_i(din.extout), .Branch_i(din.branch), .DRen_i(din.dren), .DWen_i(din.dwen),
    .RegWrite_i(din.regwrite), .RegDst_i(din.regdst), .halt_i(din.halt),
    .MemtoReg_i(din.memtoreg), .ALUSrc_i(din.alusrc), .ALUop_i(din.aluop), .Rd_i(din.rd), .Rt_i(din.rt),
    .npc_o(d0.npc), .Jaddr_o(d0.jaddr), .rdata1_o(d0.rdata1), .rdata2_o(d0.rdata2),
    .extout_o(d0.extout), .Branch_o(d0.branch), .DRen_o(d0.dren), .DWen_o(d0.dwen),
    .RegWrite_o(d0.regwrite), .RegDst_o(d0.regdst), .halt_o(d0.halt),
    .MemtoReg_o(d0.memtoreg), .ALUSrc_o(d0.alusrc), .ALUop_o(d0.aluop), .Rd_o(d0.rd), .Rt_o(d0.rt),
    .valid_o(v0), .bubble_cnt(bub0), .stall_cnt(stl0)
  );

  idex_latch #(.CNT_W(4)) u1 (
    .CLK(CLK), .nRST(nRST), .en(en), .stall(stall), .flush(flush),
    .npc_i(din.npc), .Jaddr_i(din.jaddr), .rdata1_i(din.rdata1), .rdata2_i(din.rdata2),
    .extout_i(din.extout), .Branch_i(din.branch), .DRen_i(din.dren), .DWen_i(din.dwen),
    .RegWrite_i(din.regwrite), .RegDst_i(din.regdst), .halt_i(din.halt),
    .MemtoReg_i(din.memtoreg), .ALUSrc_i(din.alusrc), .ALUop_i(din.aluop), .Rd_i(din.rd), .Rt_i(din.rt),
    .npc_o(d1.npc), .Jaddr_o(d1.jaddr), .rdata1_o(d1.rdata1), .rdata2_o(d1.rdata2),
    .extout_o(d1.extout), .Branch_o(d1.branch), .DRen_o(d1.dren), .DWen_o(d1.dwen),
    .RegWrite_o(d1.regwrite), .RegDst_o(d1.regdst), .halt_o(d1.halt),
    .MemtoReg_o(d1.memtoreg), .ALUSrc_o(d1.alusrc), .ALUop_o(d1.aluop), .Rd_o(d1.rd), .Rt_o(d1.rt),
    .valid_o(v1), .bubble_cnt(bub1), .stall_cnt(stl1)
  );

  task automatic chk(input string n, input logic [183:0] act, input logic [183:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return v > mx ? mx : v;
  endfunction

  task automatic model_reset();
    m = '0; mv = 0; mb = 0; ms = 0;
  endtask

  // Spec rules: hold beats everything; flush/stall give one bubble; halt is sticky.
  task automatic model_edge();
    logic h;
    h = m.halt;
    if (!en) ms++;
    else if (flush || stall) begin m = '0; m.halt = h; mv = 0; mb++; end
    else begin m = din; m.halt = h | din.halt; mv = 1; end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".fields"}, d0, m);
    chk({tag, ".valid"}, 184'(v0), 184'(mv));
    chk({tag, ".bub16"}, 184'(bub0), 184'(sat(mb, 65535)));
    chk({tag, ".stl16"}, 184'(stl0), 184'(sat(ms, 65535)));
    chk({tag, ".bub4"}, 184'(bub1), 184'(sat(mb, 15)));
    chk({tag, ".stl4"}, 184'(stl1), 184'(sat(ms, 15)));
    chk({tag, ".fields4"}, d1, m);
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge CLK);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    nRST = 0;
    #1;
    model_reset();
    check_all("rst_async");
    @(posedge CLK);
    #1;
    nRST = 1;
  endtask

  function automatic fields_t rnd_fields();
    fields_t f;
    f.npc = $urandom; f.jaddr = $urandom; f.rdata1 = $urandom; f.rdata2 = $urandom;
    f.extout = $urandom;
    {f.branch, f.dren, f.dwen, f.regwrite, f.regdst} = 5'($urandom);
    f.halt = ($urandom % 16) == 0;
    {f.memtoreg, f.alusrc, f.aluop, f.rd, f.rt} = 18'($urandom);
    return f;
  endfunction

  vec_t vt[11];

  initial begin
    vt[0]  = '{1,0,0,0, 32'h10,       32'h10, 0, 1, 0, 0};
    vt[1]  = '{0,0,0,0, 32'h55555555, 32'h10, 0, 1, 0, 1};
    vt[2]  = '{0,0,0,0, 32'h55555555, 32'h10, 0, 1, 0, 2};
    vt[3]  = '{0,0,0,0, 32'h55555555, 32'h10, 0, 1, 0, 3};
    vt[4]  = '{1,0,1,0, 32'h20,       32'h0,  0, 0, 1, 3};
    vt[5]  = '{1,1,1,0, 32'h20,       32'h0,  0, 0, 2, 3};
    vt[6]  = '{0,0,1,0, 32'h30,       32'h0,  0, 0, 2, 4};
    vt[7]  = '{1,0,0,1, 32'h40,       32'h40, 1, 1, 2, 4};
    vt[8]  = '{1,0,1,0, 32'h44,       32'h0,  1, 0, 3, 4};
    vt[9]  = '{1,0,0,0, 32'h50,       32'h50, 1, 1, 3, 4};
    vt[10] = '{1,1,0,0, 32'h60,       32'h0,  1, 0, 4, 4};

    // Reset with busy inputs: outputs stay clear, then an en=0 edge keeps them clear.
    din = '1; din.npc = 32'h104; din.regwrite = 1; en = 1;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_all("reset");
    en = 0;
    nRST = 1;
    step("post_rst_hold");
    chk("post_rst_npc", 184'(d0.npc), 184'(0));

    do_reset();
    din = '0; en = 1; din.npc = 32'h10; din.rdata1 = 32'hDEADBEEF; din.rd = 5;
    din.aluop = 4'h3; din.regwrite = 1;
    step("load");
    chk("load_npc", 184'(d0.npc), 184'(32'h10));
    chk("load_rdata1", 184'(d0.rdata1), 184'(32'hDEADBEEF));
    chk("load_rd", 184'(d0.rd), 184'(5));
    chk("load_aluop", 184'(d0.aluop), 184'(3));
    chk("load_regwrite", 184'(d0.regwrite), 184'(1));

    do_reset();
    for (int i = 0; i < 11; i++) begin
      din = '1; din.halt = vt[i].halt; din.npc = vt[i].npc;
      en = vt[i].en; stall = vt[i].stall; flush = vt[i].flush;
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.npc", i), 184'(d0.npc), 184'(vt[i].e_npc));
      chk($sformatf("vec%0d.halt", i), 184'(d0.halt), 184'(vt[i].e_halt));
      chk($sformatf("vec%0d.valid", i), 184'(v0), 184'(vt[i].e_valid));
      chk($sformatf("vec%0d.bub", i), 184'(bub0), 184'(vt[i].e_bub));
      chk($sformatf("vec%0d.stl", i), 184'(stl0), 184'(vt[i].e_stl));
      if (vt[i].flush || vt[i].stall)
        chk($sformatf("vec%0d.noside", i), 184'({d0.regwrite, d0.dren, d0.dwen, d0.branch}), 184'(0));
    end
    // Async reset while halted and mid-bubble clears immediately.
    nRST = 0;
    #1;
    chk("halt_rst", 184'(d0.halt), 184'(0));
    chk("valid_rst", 184'(v0), 184'(0));
    en = 0; stall = 0; flush = 0;
    @(posedge CLK);
    #1;
    nRST = 1;
    model_reset();

    for (int i = 0; i < 400; i++) begin
      din = rnd_fields();
      en = ($urandom % 4) != 0;
      stall = ($urandom % 5) == 0;
      flush = ($urandom % 5) == 0;
      if (($urandom % 60) == 0) do_reset();
      else step("rand");
    end

    do_reset();
    en = 0;
    for (int i = 0; i < 20; i++) begin
      din = rnd_fields();
      step("sat");
    end
    chk("sat_stl4", 184'(stl1), 184'(15));
    chk("sat_stl16", 184'(stl0), 184'(20));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/idex_latch.md
Name: idex_latch

Overview:
- ID/EX pipeline register: the consumer end of the ID/EX interface bundle. Connects to its ieif modport.
- Samples decode-stage values (_i) on CLK and presents them to execute (_o).
- Supports hold (stall), bubble insertion (flush) and a sticky halt.
- Keeps saturating bubble/stall counters for pipeline performance debug.

Parameters:
- CNT_W, 16, width of the bubble_cnt and stall_cnt performance counters.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- en  in  1  pipeline advance enable (ihit-qualified); 0 = hold all state.
- stall  in  1  load-use hazard; 1 = insert bubble into EX while decode holds.
- flush  in  1  branch/jump taken in EX; 1 = squash instruction entering EX.
- npc_i/npc_o, Jaddr_i/Jaddr_o, rdata1_i/rdata1_o, rdata2_i/rdata2_o, extout_i/extout_o  in/out  32 each  data fields.
- Branch_i/o, DRen_i/o, DWen_i/o, RegWrite_i/o, RegDst_i/o, halt_i/o  in/out  1 each  control fields.
- MemtoReg_i/o, ALUSrc_i/o  in/out  2 each  mux selects.
- ALUop_i/ALUop_o  in/out  4  aluop_t.
- Rd_i/Rd_o, Rt_i/Rt_o  in/out  5  regbits_t.
- valid_o  out  1  1 = EX holds a real instruction, 0 = bubble.
- bubble_cnt  out  CNT_W  bubbles inserted since reset, saturating.
- stall_cnt  out  CNT_W  cycles held by en=0 since reset, saturating.

Behaviour:
- Reset (nRST=0, async): every _o field = 0 (ALUop_o = ALU_SLL encoding 0), valid_o=0, counters=0.
- The register updates only at a rising CLK edge. Latency from _i to _o is 1 cycle. There is no combinational path from _i to _o.
- Priority per edge, highest first:
  - en=0: hold. All fields, valid_o and bubble_cnt are unchanged. stall_cnt increments. flush and stall are ignored.
  - en=1, flush=1: bubble. All data/control/reg fields = 0, valid_o=0, bubble_cnt increments. halt_o follows the sticky-halt rule below.
  - en=1, stall=1, flush=0: bubble, handled identically to flush.
  - en=1, flush=0, stall=0: load. Every _o = its _i, valid_o=1.
- flush=1 and stall=1 together: one bubble only. bubble_cnt increments by 1.
- Sticky halt:
  - Once halt_o=1 it stays 1 through hold, bubble and load until nRST.
  - Bubbles never clear halt_o.
  - A loaded halt_i=1 sets it.
- Bubble encoding guarantees no side effects downstream: RegWrite_o=0, DRen_o=0, DWen_o=0, Branch_o=0.
- Counters saturate at 2^CNT_W-1; they do not wrap.
- Reset mid-stall or mid-flush: outputs clear immediately (async). The first edge after nRST rises applies normal priority.
- Inputs are sampled only at the edge. Glitches between edges have no effect.

Test Plan:
- Reset: drive all _i = nonzero (npc_i=0x00000104, RegWrite_i=1), nRST=0 -> all _o=0, valid_o=0, counters=0. Outputs stay 0 until the first enabled edge after release.
- Load: en=1, npc_i=0x00000010, rdata1_i=0xDEADBEEF, Rd_i=5, ALUop_i=4'h3, RegWrite_i=1 -> one edge later npc_o=0x10, rdata1_o=0xDEADBEEF, Rd_o=5, ALUop_o=3, RegWrite_o=1, valid_o=1.
- Hold: after load, en=0 for 3 edges while _i changes to 0x55555555 -> _o unchanged, stall_cnt=3, bubble_cnt=0.
- Flush/stall bubble:
  - en=1, flush=1, RegWrite_i=1, DWen_i=1 -> next edge RegWrite_o=0, DWen_o=0, valid_o=0, bubble_cnt=1.
  - Then flush=1 and stall=1 together -> bubble_cnt=2.
  - Then en=0, flush=1 -> no change, stall_cnt increments.
- Sticky halt: load halt_i=1 -> halt_o=1. Then flush=1 edge, then load with halt_i=0 -> halt_o remains 1. Assert nRST=0 -> halt_o=0 immediately.
- Saturation: CNT_W=4, hold en=0 for 20 edges -> stall_cnt reaches 15 and stays 15.
